// File: rtl/access_port_sequencer_pkg.sv
// Shared network definitions for the access port sequencer: address/data widths,
// the sequencer FSM encoding and the queued request entry layout.
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package access_port_sequencer_pkg;

  localparam int unsigned NET_ADDR_W  = `NETWORK_ADDRESS_WIDTH;
  localparam int unsigned BANK_ADDR_W = `CACHE_BANK_ADDRESS_WIDTH;
  localparam int unsigned ADDR_W      = NET_ADDR_W + BANK_ADDR_W;
  localparam int unsigned DATA_W      = `DATA_WIDTH;
  localparam int unsigned ENTRY_W     = 1 + ADDR_W + DATA_W;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_READ = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_entry_t;

endpackage

// File: rtl/access_request_fifo.sv
// Request queue for the access port sequencer: power-of-two circular buffer
// with occupancy count; head entry is presented combinationally.
module access_request_fifo
  import access_port_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  req_entry_t             wdata_i,
  output req_entry_t             head_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push, do_pop;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign do_push = push_i && !full_c;
  assign do_pop  = pop_i && !empty_c;
  assign head_c  = req_entry_t'(mem_q[rd_ptr_q]);
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= ENTRY_W'(wdata_i);
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/access_port_sequencer.sv
// Access port sequencer: queues client read/write requests and issues them one at a
// time onto a network port, waiting for each read response or timing it out.
module access_port_sequencer
  import access_port_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic                   reqWrite,
  input  logic [ADDR_W-1:0]      reqAddress,
  input  logic [DATA_W-1:0]      reqData,
  output logic [ADDR_W-1:0]      destinationAddressOut,
  output logic                   readOut,
  output logic                   writeOut,
  output logic [DATA_W-1:0]      dataOut,
  input  logic                   readReadyIn,
  input  logic [DATA_W-1:0]      dataIn,
  output logic                   respValid,
  output logic [DATA_W-1:0]      respData,
  output logic                   timeoutError,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic              read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              timeout_q, timeout_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  req_entry_t        fifo_wdata, fifo_head;

  assign fifo_wdata = '{write: reqWrite, addr: reqAddress, data: reqData};
  assign reqReady   = !fifo_full;

  access_request_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (reqValid),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_o (occupancy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      dest_q       <= '0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      timeout_q    <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      timeout_q    <= timeout_d;
      wait_q       <= wait_d;
    end
  end

  // Issue from the queue in IDLE; in WAIT_READ the readOut cycle itself is not a sample cycle.
  always_comb begin
    state_d      = state_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    dest_d       = dest_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    timeout_d    = timeout_q;
    wait_d       = wait_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          dest_d   = fifo_head.addr;
          data_d   = fifo_head.data;
          if (fifo_head.write) begin
            write_d = 1'b1;
          end else begin
            read_d  = 1'b1;
            wait_d  = '0;
            state_d = ST_WAIT_READ;
          end
        end
      end
      ST_WAIT_READ: begin
        if (!read_q) begin
          if (readReadyIn) begin
            resp_valid_d = 1'b1;
            resp_data_d  = dataIn;
            state_d      = ST_IDLE;
          end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign readOut               = read_q;
  assign writeOut              = write_q;
  assign destinationAddressOut = dest_q;
  assign dataOut               = data_q;
  assign respValid             = resp_valid_q;
  assign respData              = resp_data_q;
  assign timeoutError          = timeout_q;

endmodule

// File: tb/tb_access_port_sequencer.sv
// Self-checking bench for access_port_sequencer: directed vector table, hand-written
// timeout/reset sequences, then random traffic against a transaction-level model.
module tb_access_port_sequencer;
  import access_port_sequencer_pkg::*;

  localparam int unsigned TB_DEPTH   = 4;
  localparam int unsigned TB_TIMEOUT = 8;
  localparam int unsigned OCC_W      = $clog2(TB_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset, reqValid, reqReady, reqWrite;
  logic [ADDR_W-1:0] reqAddress, destinationAddressOut;
  logic [DATA_W-1:0] reqData, dataOut, dataIn, respData;
  logic              readOut, writeOut, readReadyIn, respValid, timeoutError;
  logic [OCC_W-1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  access_port_sequencer #(.DEPTH(TB_DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .reqValid              (reqValid),
    .reqReady              (reqReady),
    .reqWrite              (reqWrite),
    .reqAddress            (reqAddress),
    .reqData               (reqData),
    .destinationAddressOut (destinationAddressOut),
    .readOut               (readOut),
    .writeOut              (writeOut),
    .dataOut               (dataOut),
    .readReadyIn           (readReadyIn),
    .dataIn                (dataIn),
    .respValid             (respValid),
    .respData              (respData),
    .timeoutError          (timeoutError),
    .occupancy             (occupancy)
  );

  typedef struct {
    bit                rst, vld, wr, rr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, di;
    bit                erdy, erd, ewr, cd, erv, eto;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed, erdat;
    int                eocc;
  } vec_t;

  vec_t tbl [16];

  // Transaction-level reference: request list, one outstanding read aged in cycles.
  req_entry_t        m_q [$];
  bit                m_pending;
  int                m_age;
  bit                m_rd, m_wr, m_rv, m_to;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data, m_rdata;

  function automatic vec_t mk(input bit rst, input bit vld, input bit wr,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input bit rr, input logic [DATA_W-1:0] di,
                              input bit erdy, input bit erd, input bit ewr,
                              input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                              input bit cd, input bit erv, input logic [DATA_W-1:0] erdat,
                              input bit eto, input int eocc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.wr = wr; v.a = a; v.d = d; v.rr = rr; v.di = di;
    v.erdy = erdy; v.erd = erd; v.ewr = ewr; v.ea = ea; v.ed = ed; v.cd = cd;
    v.erv = erv; v.erdat = erdat; v.eto = eto; v.eocc = eocc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit vld, input bit wr,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input bit rr, input logic [DATA_W-1:0] di);
    reset = rst; reqValid = vld; reqWrite = wr; reqAddress = a; reqData = d;
    readReadyIn = rr; dataIn = di;
  endtask

  task automatic model_step(input bit rst, input bit vld, input bit wr,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit rr, input logic [DATA_W-1:0] di);
    req_entry_t e;
    bit         room;
    room = (m_q.size() < int'(TB_DEPTH));
    if (rst) begin
      m_q.delete();
      m_pending = 0; m_age = 0;
      m_rd = 0; m_wr = 0; m_rv = 0; m_to = 0;
      m_addr = '0; m_data = '0; m_rdata = '0;
    end else begin
      m_rd = 0; m_wr = 0; m_rv = 0;
      if (m_pending) begin
        if (m_age >= 1 && rr) begin
          m_rv = 1; m_rdata = di; m_pending = 0;
        end else if (m_age >= int'(TB_TIMEOUT)) begin
          m_to = 1; m_pending = 0;
        end
        m_age++;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_addr = e.addr; m_data = e.data;
        m_wr = e.write; m_rd = !e.write;
        if (!e.write) begin
          m_pending = 1; m_age = 0;
        end
      end
      if (vld && room) m_q.push_back('{write: wr, addr: a, data: d});
    end
  endtask

  bit                r_rst, r_vld, r_wr, r_rr;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_d, r_di;
  int                n;
  bit                saw_rv;

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);

    tbl[0]  = mk(1,0,0,8'h00,8'h00,0,8'h00, 1,0,0,8'h00,8'h00,1,0,8'h00,0,0);
    tbl[1]  = mk(0,1,1,8'h12,8'h5A,0,8'h00, 1,0,0,8'h00,8'h00,1,0,8'h00,0,1);
    tbl[2]  = mk(0,0,0,8'h00,8'h00,0,8'h00, 1,0,1,8'h12,8'h5A,1,0,8'h00,0,0);
    tbl[3]  = mk(0,0,0,8'h00,8'h00,0,8'h00, 1,0,0,8'h12,8'h5A,1,0,8'h00,0,0);
    tbl[4]  = mk(0,1,0,8'h33,8'h00,0,8'h00, 1,0,0,8'h12,8'h5A,1,0,8'h00,0,1);
    tbl[5]  = mk(0,1,1,8'h21,8'hA1,0,8'h00, 1,1,0,8'h33,8'h00,0,0,8'h00,0,1);
    tbl[6]  = mk(0,1,1,8'h22,8'hA2,1,8'hEE, 1,0,0,8'h33,8'h00,0,0,8'h00,0,2);
    tbl[7]  = mk(0,1,1,8'h23,8'hA3,0,8'h00, 1,0,0,8'h33,8'h00,0,0,8'h00,0,3);
    tbl[8]  = mk(0,1,1,8'h24,8'hA4,0,8'h00, 1,0,0,8'h33,8'h00,0,0,8'h00,0,4);
    tbl[9]  = mk(0,1,1,8'h55,8'hB5,1,8'h5A, 0,0,0,8'h33,8'h00,0,1,8'h5A,0,4);
    tbl[10] = mk(0,1,1,8'h55,8'hB5,0,8'h00, 0,0,1,8'h21,8'hA1,1,0,8'h5A,0,3);
    tbl[11] = mk(0,1,1,8'h55,8'hB5,0,8'h00, 1,0,1,8'h22,8'hA2,1,0,8'h5A,0,3);
    tbl[12] = mk(0,0,0,8'h00,8'h00,0,8'h00, 1,0,1,8'h23,8'hA3,1,0,8'h5A,0,2);
    tbl[13] = mk(0,0,0,8'h00,8'h00,0,8'h00, 1,0,1,8'h24,8'hA4,1,0,8'h5A,0,1);
    tbl[14] = mk(0,0,0,8'h00,8'h00,0,8'h00, 1,0,1,8'h55,8'hB5,1,0,8'h5A,0,0);
    tbl[15] = mk(0,0,0,8'h00,8'h00,1,8'h77, 1,0,0,8'h55,8'hB5,1,0,8'h5A,0,0);

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].rr, tbl[i].di);
      chk($sformatf("v%0d reqReady", i), 32'(reqReady), 32'(tbl[i].erdy));
      @(negedge clk);
      chk($sformatf("v%0d readOut", i), 32'(readOut), 32'(tbl[i].erd));
      chk($sformatf("v%0d writeOut", i), 32'(writeOut), 32'(tbl[i].ewr));
      chk($sformatf("v%0d destAddr", i), 32'(destinationAddressOut), 32'(tbl[i].ea));
      if (tbl[i].cd) chk($sformatf("v%0d dataOut", i), 32'(dataOut), 32'(tbl[i].ed));
      chk($sformatf("v%0d respValid", i), 32'(respValid), 32'(tbl[i].erv));
      chk($sformatf("v%0d respData", i), 32'(respData), 32'(tbl[i].erdat));
      chk($sformatf("v%0d timeoutError", i), 32'(timeoutError), 32'(tbl[i].eto));
      chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(tbl[i].eocc));
    end

    // Read with no response: timeout after TB_TIMEOUT sample cycles, then the queued write issues.
    drive(0, 1, 0, 8'h44, 8'h00, 0, 8'h00);
    @(negedge clk);
    drive(0, 1, 1, 8'h45, 8'hC5, 0, 8'h00);
    @(negedge clk);
    chk("to readOut", 32'(readOut), 32'd1);
    drive(0, 0, 0, '0, '0, 0, '0);
    n = 0; saw_rv = 0;
    while (timeoutError !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (respValid === 1'b1) saw_rv = 1;
    end
    chk("to cycles", 32'(n), 32'(TB_TIMEOUT + 1));
    chk("to respValid", 32'(saw_rv), 32'd0);
    chk("to occupancy", 32'(occupancy), 32'd1);
    @(negedge clk);
    chk("to next writeOut", 32'(writeOut), 32'd1);
    chk("to next addr", 32'(destinationAddressOut), 32'h45);
    chk("to next data", 32'(dataOut), 32'hC5);

    // Reset while a read is outstanding and a write is queued.
    drive(0, 1, 0, 8'h66, 8'h00, 0, 8'h00);
    @(negedge clk);
    drive(0, 1, 1, 8'h67, 8'hC7, 0, 8'h00);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("rw sticky timeout", 32'(timeoutError), 32'd1);
    drive(1, 0, 0, '0, '0, 0, '0);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, 1, 8'h99);
    chk("rw occupancy", 32'(occupancy), 32'd0);
    chk("rw timeoutError", 32'(timeoutError), 32'd0);
    chk("rw respData", 32'(respData), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, 0, '0);
    chk("rw respValid a", 32'(respValid), 32'd0);
    chk("rw writeOut a", 32'(writeOut), 32'd0);
    @(negedge clk);
    chk("rw respValid b", 32'(respValid), 32'd0);
    chk("rw writeOut b", 32'(writeOut), 32'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      r_rst = (c == 0) || ($urandom_range(99) < 2);
      r_vld = ($urandom_range(99) < 60);
      r_wr  = ($urandom_range(1) == 1);
      r_a   = ADDR_W'($urandom);
      r_d   = DATA_W'($urandom);
      r_rr  = ($urandom_range(99) < 25);
      r_di  = DATA_W'($urandom);
      drive(r_rst, r_vld, r_wr, r_a, r_d, r_rr, r_di);
      if (c > 0) chk("rnd reqReady", 32'(reqReady), 32'(m_q.size() < int'(TB_DEPTH)));
      model_step(r_rst, r_vld, r_wr, r_a, r_d, r_rr, r_di);
      @(negedge clk);
      chk("rnd readOut", 32'(readOut), 32'(m_rd));
      chk("rnd writeOut", 32'(writeOut), 32'(m_wr));
      chk("rnd destAddr", 32'(destinationAddressOut), 32'(m_addr));
      if (m_wr) chk("rnd dataOut", 32'(dataOut), 32'(m_data));
      chk("rnd respValid", 32'(respValid), 32'(m_rv));
      chk("rnd respData", 32'(respData), 32'(m_rdata));
      chk("rnd timeoutError", 32'(timeoutError), 32'(m_to));
      chk("rnd occupancy", 32'(occupancy), 32'(m_q.size()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
